// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU lab top: opcodes, FSM states,
// flag layout and the combinational ALU evaluation function.
package alu_seq_pkg;

  localparam int MAX_W = 12;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_ENTER_OP,
    S_CALC,
    S_SHOW
  } state_t;

  typedef struct packed {
    logic [3:0]       flags;
    logic [MAX_W-1:0] result;
  } alu_out_t;

  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] state_tag(input state_t st);
    case (st)
      S_ENTER_A:  return 4'b0001;
      S_ENTER_B:  return 4'b0010;
      S_ENTER_OP: return 4'b0100;
      S_CALC:     return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

  // Evaluates at width w (<= MAX_W); operands and result live in the low w bits.
  function automatic alu_out_t alu_eval(input int w, input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b, input logic [5:0] op);
    logic [MAX_W:0]          carry_bit;
    logic [MAX_W-1:0]        mask, msb, a_m, b_m, b_add, res;
    logic [MAX_W:0]          sum;
    logic signed [MAX_W-1:0] a_sx;
    logic                    carry, ovf, sa, sb, sr, big_shift;
    alu_out_t                o;
    carry_bit = {{MAX_W{1'b0}}, 1'b1} << w;
    mask      = carry_bit[MAX_W-1:0] - MAX_W'(1);
    msb       = mask ^ (mask >> 1);
    a_m       = a & mask;
    b_m       = b & mask;
    b_add     = '0;
    sum       = '0;
    res       = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    big_shift = (32'(b_m) >= 32'(w));
    a_sx      = ((a_m & msb) != '0) ? (a_m | ~mask) : a_m;
    case (op)
      OP_ADD, OP_SUB: begin
        b_add = (op == OP_SUB) ? (~b_m & mask) : b_m;
        sum   = {1'b0, a_m} + {1'b0, b_add} + {{MAX_W{1'b0}}, (op == OP_SUB)};
        res   = sum[MAX_W-1:0] & mask;
        carry = |(sum & carry_bit);
        sa    = (a_m & msb) != '0;
        sb    = (b_add & msb) != '0;
        sr    = (res & msb) != '0;
        ovf   = (sa == sb) && (sr != sa);
      end
      OP_AND:  res = a_m & b_m;
      OP_OR:   res = a_m | b_m;
      OP_XOR:  res = a_m ^ b_m;
      OP_NOR:  res = ~(a_m | b_m) & mask;
      OP_SRL:  res = big_shift ? '0 : (a_m >> b_m);
      OP_SRA:  res = big_shift ? (((a_m & msb) != '0) ? mask : '0)
                               : (MAX_W'(a_sx >>> b_m) & mask);
      default: res = '0;
    endcase
    o.result            = res;
    o.flags[FLAG_ZERO]  = (res == '0);
    o.flags[FLAG_NEG]   = (res & msb) != '0;
    o.flags[FLAG_CARRY] = carry;
    o.flags[FLAG_OVF]   = ovf;
    return o;
  endfunction

endpackage

// File: rtl/alu_hist_buf.sv
// Result history ring with saturating fill count, a browse offset (0 = newest)
// and a registered read of the currently viewed entry.
module alu_hist_buf #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_data,
  input  logic                           i_older,
  input  logic                           i_newer,
  output logic [WIDTH-1:0]               o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_view, w_wr_ptr_nxt, w_view_nxt, w_rd_idx;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_rd_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    w_view_nxt   = r_view;
    if (i_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      if (r_count != CW'(DEPTH)) w_count_nxt = r_count + CW'(1);
      w_view_nxt = '0;
    end else if (i_older) begin
      if (CW'(r_view) + CW'(1) < r_count) w_view_nxt = r_view + PW'(1);
    end else if (i_newer) begin
      if (r_view != '0) w_view_nxt = r_view - PW'(1);
    end
    // Read address follows the post-edge pointer/offset so led tracks in one cycle.
    w_rd_idx = w_wr_ptr_nxt - PW'(1) - w_view_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_view    <= '0;
      r_rd_data <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_count   <= w_count_nxt;
      r_view    <= w_view_nxt;
      r_rd_data <= i_push ? i_push_data : r_mem[w_rd_idx];
    end
  end

  // NOTE: storage is not reset; r_count alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;

endmodule

// File: rtl/btn_onepulse.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge
// detector producing a single-cycle pulse per press.
module btn_onepulse (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_prev <= r_sync[1];
    end
  end

  assign o_pulse = r_sync[1] & ~r_prev;

endmodule

// File: rtl/alu_seq_top_basys3.sv
// Basys3 ALU lab top: single-button guided operand/opcode entry, one-cycle
// compute, and a browsable history of results with their flags.
module alu_seq_top_basys3
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HIST_DEPTH = 4
) (
  input  logic        clk100,
  input  logic        btnU,
  input  logic [15:0] sw,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        btnR,
  output logic [15:0] led
);

  localparam int EW = DATA_WIDTH + 4;

  logic                            w_pc, w_pl, w_pr;
  state_t                          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]           r_a, r_b;
  logic [5:0]                      r_op;
  alu_out_t                        w_alu;
  logic                            w_push, w_older, w_newer;
  logic [EW-1:0]                   w_push_data, w_view;
  logic [$clog2(HIST_DEPTH+1)-1:0] w_hist_count;
  logic                            w_unused;

  btn_onepulse u_pulse_c (.i_clk(clk100), .i_rst(btnU), .i_btn(btnC), .o_pulse(w_pc));
  btn_onepulse u_pulse_l (.i_clk(clk100), .i_rst(btnU), .i_btn(btnL), .o_pulse(w_pl));
  btn_onepulse u_pulse_r (.i_clk(clk100), .i_rst(btnU), .i_btn(btnR), .o_pulse(w_pr));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ENTER_A:  if (w_pc) w_state_nxt = S_ENTER_B;
      S_ENTER_B:  if (w_pc) w_state_nxt = S_ENTER_OP;
                  else if (w_pl) w_state_nxt = S_ENTER_A;
      S_ENTER_OP: if (w_pc) begin
                    if (op_valid(sw[5:0])) w_state_nxt = S_CALC;
                  end else if (w_pl) begin
                    w_state_nxt = S_ENTER_B;
                  end
      S_CALC:     w_state_nxt = S_SHOW;
      S_SHOW:     if (w_pc) w_state_nxt = S_ENTER_A;
      default:    w_state_nxt = S_ENTER_A;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (btnU) begin
      r_state <= S_ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ENTER_A && w_pc) r_a <= sw[DATA_WIDTH-1:0];
      if (r_state == S_ENTER_B && w_pc) r_b <= sw[DATA_WIDTH-1:0];
      if (r_state == S_ENTER_OP && w_pc && op_valid(sw[5:0])) r_op <= sw[5:0];
    end
  end

  assign w_alu       = alu_eval(DATA_WIDTH, MAX_W'(r_a), MAX_W'(r_b), r_op);
  assign w_push      = (r_state == S_CALC) && !btnU;
  assign w_push_data = {w_alu.flags, w_alu.result[DATA_WIDTH-1:0]};
  // Browsing only in SHOW; btnC outranks btnL, which outranks btnR.
  assign w_older     = (r_state == S_SHOW) && w_pl && !w_pc;
  assign w_newer     = (r_state == S_SHOW) && w_pr && !w_pl && !w_pc;

  alu_hist_buf #(.WIDTH(EW), .DEPTH(HIST_DEPTH)) u_hist (
    .i_clk      (clk100),
    .i_rst      (btnU),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_older    (w_older),
    .i_newer    (w_newer),
    .o_rd_data  (w_view),
    .o_count    (w_hist_count)
  );

  always_comb begin
    led = '0;
    if (r_state == S_SHOW) led = {w_view[EW-1 -: 4], 12'(w_view[DATA_WIDTH-1:0])};
    else                   led = {state_tag(r_state), 12'(sw[DATA_WIDTH-1:0])};
  end

  assign w_unused = ^{sw, w_alu};

endmodule

// File: tb/tb_alu_seq_top_basys3.sv
// Self-checking bench for alu_seq_top_basys3 at DATA_WIDTH=8, HIST_DEPTH=4:
// vector table through a result scoreboard plus hand-written corner sequences.
module tb_alu_seq_top_basys3;
  import alu_seq_pkg::*;

  logic        clk100 = 1'b0;
  logic        btnU, btnC, btnL, btnR;
  logic [15:0] sw, led;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [5:0]  op;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[15];

  always #5 clk100 = ~clk100;

  alu_seq_top_basys3 #(.DATA_WIDTH(8), .HIST_DEPTH(4)) dut (
    .clk100(clk100),
    .btnU  (btnU),
    .sw    (sw),
    .btnC  (btnC),
    .btnL  (btnL),
    .btnR  (btnR),
    .led   (led)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Pulse reaches the FSM two edges after press; capture on the third edge.
  // Returns on the negedge after that capture edge.
  task automatic press(input logic c, input logic l, input logic r);
    repeat (4) @(negedge clk100);
    btnC = c; btnL = l; btnR = r;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    btnC = 1'b0; btnL = 1'b0; btnR = 1'b0;
  endtask

  task automatic compute(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input logic [15:0] exp_led);
    sw = {8'h00, a};
    press(1'b1, 1'b0, 1'b0);
    sw = {8'h00, b};
    press(1'b1, 1'b0, 1'b0);
    sw = {10'h000, op};
    exp_q.push_back(exp_led);
    press(1'b1, 1'b0, 1'b0);
    check({name, " calc"}, led, 16'h8000 | {10'h000, op});
    @(negedge clk100);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, led 0x%04h", name, led);
    end else begin
      check(name, led, exp_q.pop_front());
    end
  endtask

  task automatic back_to_a();
    press(1'b1, 1'b0, 1'b0);
    check("to ENTER_A", led, 16'h1000 | {8'h00, sw[7:0]});
  endtask

  initial begin
    logic [7:0] older_exp[5];
    logic [7:0] newer_exp[5];
    older_exp = '{8'd4, 8'd3, 8'd2, 8'd2, 8'd2};
    newer_exp = '{8'd3, 8'd4, 8'd5, 8'd5, 8'd5};

    vecs[0]  = '{a: 8'h7F, b: 8'h01, op: OP_ADD, exp_led: 16'hA080};
    vecs[1]  = '{a: 8'h05, b: 8'h05, op: OP_SUB, exp_led: 16'h5000};
    vecs[2]  = '{a: 8'h80, b: 8'h01, op: OP_SRA, exp_led: 16'h20C0};
    vecs[3]  = '{a: 8'h00, b: 8'h01, op: OP_SUB, exp_led: 16'h20FF};
    vecs[4]  = '{a: 8'h80, b: 8'h80, op: OP_ADD, exp_led: 16'hD000};
    vecs[5]  = '{a: 8'h80, b: 8'h01, op: OP_SUB, exp_led: 16'hC07F};
    vecs[6]  = '{a: 8'hF0, b: 8'h3C, op: OP_AND, exp_led: 16'h0030};
    vecs[7]  = '{a: 8'hF0, b: 8'h0F, op: OP_OR,  exp_led: 16'h20FF};
    vecs[8]  = '{a: 8'hAA, b: 8'hFF, op: OP_XOR, exp_led: 16'h0055};
    vecs[9]  = '{a: 8'h0F, b: 8'h30, op: OP_NOR, exp_led: 16'h20C0};
    vecs[10] = '{a: 8'h80, b: 8'h07, op: OP_SRL, exp_led: 16'h0001};
    vecs[11] = '{a: 8'hFF, b: 8'h08, op: OP_SRL, exp_led: 16'h1000};
    vecs[12] = '{a: 8'h80, b: 8'h09, op: OP_SRA, exp_led: 16'h20FF};
    vecs[13] = '{a: 8'h7F, b: 8'h0C, op: OP_SRA, exp_led: 16'h1000};
    vecs[14] = '{a: 8'h12, b: 8'h34, op: OP_ADD, exp_led: 16'h0046};

    btnU = 1'b1; btnC = 1'b0; btnL = 1'b0; btnR = 1'b0;
    sw   = 16'h005A;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("reset led", led, 16'h105A);
    check("reset count", 16'(dut.w_hist_count), 16'h0000);
    btnU = 1'b0;
    sw = 16'hFFC3;
    #1;
    check("sw echo masked", led, 16'h10C3);

    for (int i = 0; i < 15; i++) begin
      compute($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_led);
      back_to_a();
    end

    // Invalid opcode holds ENTER_OP; btnL steps back to ENTER_B.
    sw = 16'h0011; press(1'b1, 1'b0, 1'b0);
    sw = 16'h0022; press(1'b1, 1'b0, 1'b0);
    sw = 16'h003F; press(1'b1, 1'b0, 1'b0);
    check("invalid op stays", led, 16'h403F);
    press(1'b0, 1'b1, 1'b0);
    check("btnL to ENTER_B", led, 16'h203F);

    // btnC wins over btnL in ENTER_B: B is captured.
    sw = 16'h0033; press(1'b1, 1'b1, 1'b0);
    check("C+L captures B", led, 16'h4033);
    sw = {10'h000, OP_ADD};
    exp_q.push_back(16'h0044);
    press(1'b1, 1'b0, 1'b0);
    check("C+L calc", led, 16'h8020);
    @(negedge clk100);
    check("C+L result", led, exp_q.pop_front());
    back_to_a();

    for (int k = 1; k <= 5; k++) begin
      compute($sformatf("hist%0d", k), 8'(k), 8'h00, OP_ADD, 16'(k));
      if (k != 5) back_to_a();
    end
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 1'b0);
      check($sformatf("older%0d", i), led, {8'h00, older_exp[i]});
    end
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b0, 1'b1);
      check($sformatf("newer%0d", i), led, {8'h00, newer_exp[i]});
    end
    back_to_a();

    // Reset from ENTER_OP.
    sw = 16'h0001; press(1'b1, 1'b0, 1'b0);
    sw = 16'h0002; press(1'b1, 1'b0, 1'b0);
    check("at ENTER_OP", led, 16'h4002);
    btnU = 1'b1;
    @(posedge clk100);
    @(negedge clk100);
    check("rst in OP led", led, 16'h1002);
    check("rst in OP count", 16'(dut.w_hist_count), 16'h0000);
    btnU = 1'b0;

    // Reset during CALC: no push survives.
    compute("pre-calc", 8'h01, 8'h01, OP_ADD, 16'h0002);
    back_to_a();
    sw = 16'h0003; press(1'b1, 1'b0, 1'b0);
    sw = 16'h0004; press(1'b1, 1'b0, 1'b0);
    sw = {10'h000, OP_ADD};
    press(1'b1, 1'b0, 1'b0);
    check("in CALC", led, 16'h8020);
    btnU = 1'b1;
    @(posedge clk100);
    @(negedge clk100);
    check("rst in CALC led", led, 16'h1020);
    check("rst in CALC count", 16'(dut.w_hist_count), 16'h0000);
    btnU = 1'b0;
    @(negedge clk100);
    check("no late push", 16'(dut.w_hist_count), 16'h0000);
    check("still ENTER_A", led, 16'h1020);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
